// File: rtl/mips_run_ctrl_pkg.sv
// Shared types, default parameter values and helpers for the MIPS run controller.
package mips_run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        RUN,
        DONE,
        TIMEOUT
    } run_state_t;

    localparam int DEF_RST_CYCLES     = 2;
    localparam int DEF_TIMEOUT_CYCLES = 700;
    localparam int DEF_CNT_W          = 32;

    function automatic int unsigned popcount32(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/mips_run_ctrl_sat_counter.sv
// Saturating accumulator: adds a small increment each enabled cycle and sticks at all-ones.
module run_sat_counter #(
    parameter int W  = 32,
    parameter int IW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [IW-1:0] inc,
    output logic [W-1:0]  count
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   sum;

    always_comb begin
        sum   = {1'b0, cnt_q} + (W+1)'(inc);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = sum[W] ? '1 : sum[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for multicycle MIPS cores: reset sequencing, run-cycle count, done gathering, watchdog.
// Memory read/write statistics are built only when RUN_CTRL_MEMSTAT_EN is defined.
//
//   state   | meaning
//   IDLE    | cores held in reset, waiting for start
//   RESET   | cores held in reset for RST_CYCLES, stats cleared
//   RUN     | cores released, cycles counted, done flags gathered
//   DONE    | every core reported done, results frozen
//   TIMEOUT | watchdog expired, results frozen
module mips_run_ctrl
    import mips_run_ctrl_pkg::*;
#(
    parameter int NUM_CORES      = 1,
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] done_in,
    input  logic [NUM_CORES-1:0] mem_read_in,
    input  logic [NUM_CORES-1:0] mem_write_in,
    output logic                 core_rst,
    output logic                 running,
    output logic                 finished,
    output logic                 timed_out,
    output logic [NUM_CORES-1:0] done_mask,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     rd_count,
    output logic [CNT_W-1:0]     wr_count
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    run_state_t           state_q;
    logic [RW-1:0]        rst_cnt_q;
    logic                 core_rst_q, running_q, finished_q, timed_out_q;
    logic [NUM_CORES-1:0] done_mask_q;
    logic [CNT_W-1:0]     cycle_count_q;
    logic                 launch;

    assign launch = start && (state_q inside {IDLE, DONE, TIMEOUT});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rst_cnt_q     <= '0;
            core_rst_q    <= 1'b1;
            running_q     <= 1'b0;
            finished_q    <= 1'b0;
            timed_out_q   <= 1'b0;
            done_mask_q   <= '0;
            cycle_count_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE, TIMEOUT: begin
                    if (launch) begin
                        state_q       <= RESET;
                        rst_cnt_q     <= RW'(RST_CYCLES - 1);
                        finished_q    <= 1'b0;
                        timed_out_q   <= 1'b0;
                        done_mask_q   <= '0;
                        cycle_count_q <= '0;
                    end
                end
                RESET: begin
                    // Down-counter terminal count marks the last reset cycle.
                    if (rst_cnt_q == '0) begin
                        state_q    <= RUN;
                        core_rst_q <= 1'b0;
                        running_q  <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - RW'(1);
                    end
                end
                RUN: begin
                    done_mask_q   <= done_mask_q | done_in;
                    cycle_count_q <= cycle_count_q + CNT_W'(1);
                    if (&(done_mask_q | done_in)) begin
                        state_q    <= DONE;
                        core_rst_q <= 1'b1;
                        running_q  <= 1'b0;
                        finished_q <= 1'b1;
                    end else if (cycle_count_q == TO_LAST) begin
                        state_q     <= TIMEOUT;
                        core_rst_q  <= 1'b1;
                        running_q   <= 1'b0;
                        timed_out_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign core_rst    = core_rst_q;
    assign running     = running_q;
    assign finished    = finished_q;
    assign timed_out   = timed_out_q;
    assign done_mask   = done_mask_q;
    assign cycle_count = cycle_count_q;

`ifdef RUN_CTRL_MEMSTAT_EN
    localparam int IW = $clog2(NUM_CORES + 1);

    logic          stat_en;
    logic [IW-1:0] rd_inc, wr_inc;

    assign stat_en = (state_q == RUN);
    assign rd_inc  = IW'(popcount32(32'(mem_read_in)));
    assign wr_inc  = IW'(popcount32(32'(mem_write_in)));

    run_sat_counter #(.W(CNT_W), .IW(IW)) u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (launch),
        .en    (stat_en),
        .inc   (rd_inc),
        .count (rd_count)
    );

    run_sat_counter #(.W(CNT_W), .IW(IW)) u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (launch),
        .en    (stat_en),
        .inc   (wr_inc),
        .count (wr_count)
    );
`else
    logic unused_strobes;
    assign unused_strobes = ^{mem_read_in, mem_write_in};
    assign rd_count       = '0;
    assign wr_count       = '0;
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl: randomized runs against a per-run reference model.
module tb_mips_run_ctrl;

    localparam int NC   = 3;
    localparam int RC   = 3;
    localparam int TO   = 40;
    localparam int CW   = 6;
    localparam int SATV = (1 << CW) - 1;
`ifdef RUN_CTRL_MEMSTAT_EN
    localparam bit MEMSTAT = 1'b1;
`else
    localparam bit MEMSTAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start;
    logic [NC-1:0] done_in, mem_read_in, mem_write_in;
    logic          core_rst, running, finished, timed_out;
    logic [NC-1:0] done_mask;
    logic [CW-1:0] cycle_count, rd_count, wr_count;

    mips_run_ctrl #(
        .NUM_CORES      (NC),
        .RST_CYCLES     (RC),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .done_in      (done_in),
        .mem_read_in  (mem_read_in),
        .mem_write_in (mem_write_in),
        .core_rst     (core_rst),
        .running      (running),
        .finished     (finished),
        .timed_out    (timed_out),
        .done_mask    (done_mask),
        .cycle_count  (cycle_count),
        .rd_count     (rd_count),
        .wr_count     (wr_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int            fin_cyc;
        bit            fin;
        logic [NC-1:0] mask;
        logic [CW-1:0] cc;
        logic [CW-1:0] rd;
        logic [CW-1:0] wr;
        int            low;
    } exp_t;

    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [NC-1:0] rand_vec(input int pct);
        logic [NC-1:0] v;
        for (int i = 0; i < NC; i++) v[i] = ($urandom_range(0, 99) < pct);
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_rst"}, core_rst, 1);
        check({tag, "_running"}, running, 0);
        check({tag, "_finished"}, finished, 0);
        check({tag, "_timed_out"}, timed_out, 0);
        check({tag, "_done_mask"}, done_mask, 0);
        check({tag, "_cycle_count"}, cycle_count, 0);
        check({tag, "_rd_count"}, rd_count, 0);
        check({tag, "_wr_count"}, wr_count, 0);
    endtask

    // Monitor: pops an expected result whenever the DUT reports the end of a run.
    initial begin : monitor
        exp_t e;
        bit   have = 0;
        bit   skip = 0;
        int   low  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have = 0; skip = 0; low = 0;
                continue;
            end
            if (!core_rst) low++;
            if (finished || timed_out) begin
                if (!have) begin
                    have = 1;
                    if (q.size() == 0) begin
                        tests++; fails++; skip = 1;
                        $display("FAIL unexpected_end: finished=%0b timed_out=%0b with no run pending (cycle %0d)",
                                 finished, timed_out, cyc);
                    end else begin
                        e = q.pop_front();
                        skip = 0;
                        check("end_cycle", cyc, e.fin_cyc);
                        check("core_rst_low_cycles", low, e.low);
                        check("finished", finished, e.fin);
                        check("timed_out", timed_out, !e.fin);
                        check("running_end", running, 0);
                        check("core_rst_end", core_rst, 1);
                        check("done_mask", done_mask, e.mask);
                        check("cycle_count", cycle_count, e.cc);
                        check("rd_count", rd_count, e.rd);
                        check("wr_count", wr_count, e.wr);
                    end
                end else if (!skip) begin
                    check("frozen_done_mask", done_mask, e.mask);
                    check("frozen_cycle_count", cycle_count, e.cc);
                    check("frozen_rd_count", rd_count, e.rd);
                    check("frozen_wr_count", wr_count, e.wr);
                    check("frozen_finished", finished, e.fin);
                end
            end else if (have) begin
                have = 0; skip = 0; low = 0;
            end
        end
    end

    // mode 0: staggered single pulses, 1: done on the timeout cycle, 2: never done,
    // 3: saturating strobes, other: random. abort: rst lands in RUN cycle 20.
    task automatic do_run(input int mode, input bit abort);
        logic [NC-1:0] dv[1:TO];
        logic [NC-1:0] rv[1:TO];
        logic [NC-1:0] wv[1:TO];
        logic [NC-1:0] acc;
        int            pd, ps, len, rs, ws, c0;
        bit            fin;
        exp_t          e;

        case ($urandom_range(0, 3))
            0:       pd = 2;
            1:       pd = 5;
            2:       pd = 10;
            default: pd = 25;
        endcase
        ps = (mode == 3) ? 100 : $urandom_range(0, 100);
        if (mode == 2 || abort) pd = 0;
        for (int j = 1; j <= TO; j++) begin
            dv[j] = rand_vec(pd);
            rv[j] = rand_vec(ps);
            wv[j] = rand_vec(ps);
        end
        if (mode == 0 || mode == 1) begin
            for (int j = 1; j <= TO; j++) dv[j] = '0;
        end
        if (mode == 0) begin
            dv[5]  = 3'b001;
            dv[9]  = 3'b100;
            dv[12] = 3'b010;
        end
        if (mode == 1) dv[TO] = '1;

        acc = '0; len = TO; fin = 0;
        for (int j = 1; j <= TO; j++) begin
            acc |= dv[j];
            if (&acc) begin
                len = j; fin = 1;
                break;
            end
        end
        rs = 0; ws = 0;
        for (int j = 1; j <= len; j++) begin
            rs += $countones(rv[j]);
            ws += $countones(wv[j]);
        end

        c0        = cyc;
        e.fin_cyc = c0 + 1 + RC + len;
        e.fin     = fin;
        e.mask    = acc;
        e.cc      = CW'(len);
        e.rd      = MEMSTAT ? ((rs > SATV) ? CW'(SATV) : CW'(rs)) : '0;
        e.wr      = MEMSTAT ? ((ws > SATV) ? CW'(SATV) : CW'(ws)) : '0;
        e.low     = len;
        if (!abort) q.push_back(e);

        start = 1'b1;
        for (int k = 0; k < RC; k++) begin
            @(negedge clk);
            start        = 1'($urandom_range(0, 1));
            done_in      = rand_vec(50);
            mem_read_in  = rand_vec(50);
            mem_write_in = rand_vec(50);
        end

        if (abort) begin
            for (int j = 1; j <= 20; j++) begin
                @(negedge clk);
                start        = 1'($urandom_range(0, 1));
                done_in      = dv[j];
                mem_read_in  = rv[j];
                mem_write_in = wv[j];
                if (j == 20) rst = 1'b1;
            end
            @(negedge clk);
            check_reset_outputs("abort");
            rst   = 1'b0;
            start = 1'b0;
            @(negedge clk);
            check("abort_idle_core_rst", core_rst, 1);
            return;
        end

        for (int j = 1; j <= len; j++) begin
            @(negedge clk);
            start        = 1'($urandom_range(0, 1));
            done_in      = dv[j];
            mem_read_in  = rv[j];
            mem_write_in = wv[j];
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start        = 1'b0;
            done_in      = rand_vec(50);
            mem_read_in  = rand_vec(50);
            mem_write_in = rand_vec(50);
        end
    endtask

    initial begin : stim
        rst          = 1'b1;
        start        = 1'b0;
        done_in      = '0;
        mem_read_in  = '0;
        mem_write_in = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_core_rst", core_rst, 1);
        check("idle_running", running, 0);

        for (int r = 0; r < 12; r++) begin
            case (r)
                0: do_run(0, 1'b0);
                1: do_run(1, 1'b0);
                2: do_run(2, 1'b0);
                3: do_run(3, 1'b0);
                4: do_run(4, 1'b1);
                6: do_run(3, 1'b0);
                default: do_run(4, 1'b0);
            endcase
        end

        repeat (3) @(negedge clk);
        check("pending_results", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
